// File: rtl/axis_adc_pkt_pkg.sv
// Shared definitions for the ADC stream packetizer: FSM states, header
// field layout and the helper that assembles a header word.
package axis_adc_pkt_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2
    } pkt_state_t;

    // Header layout: packet length in the low half-word, sequence number
    // directly above it, everything else zero.
    localparam int LEN_LSB     = 0;
    localparam int LEN_W       = 16;
    localparam int SEQ_LSB     = 16;
    localparam int HDR_W       = 64;
    localparam int SEQ_FIELD_W = HDR_W - SEQ_LSB;

    // Build a zero-padded header word. Callers resize it to their beat width;
    // the sequence argument is expected to be already zero-extended.
    function automatic logic [HDR_W-1:0] build_header(
        input logic [LEN_W-1:0]       len,
        input logic [SEQ_FIELD_W-1:0] seq
    );
        logic [HDR_W-1:0] hdr;
        hdr                        = '0;
        hdr[LEN_LSB +: LEN_W]      = len;
        hdr[SEQ_LSB +: SEQ_FIELD_W] = seq;
        return hdr;
    endfunction

endpackage

// File: rtl/axis_adc_packetizer.sv
// Frames a continuous AXI-Stream sample feed into packets of one header beat
// followed by PACKET_LEN samples, tlast on the final sample. The header
// carries the packet length and a wrapping sequence number so the transport
// side can spot lost packets. All m_axis outputs come straight from flops.
//
// Legal parameters: DATA_WIDTH >= 32, 1 <= PACKET_LEN <= 65535,
// SEQ_WIDTH <= DATA_WIDTH-16.
module axis_adc_packetizer
    import axis_adc_pkt_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int PACKET_LEN = 256,
    parameter int SEQ_WIDTH  = 16
) (
    input  logic                  axis_aclk,
    input  logic                  axis_aresetn,

    input  logic                  s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,

    output logic                  m_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,

    input  logic                  i_enable,
    output logic                  o_busy,
    output logic [31:0]           o_packet_count
);

    pkt_state_t            state_q;
    pkt_state_t            state_d;
    logic [15:0]           beat_cnt_q;
    logic [SEQ_WIDTH-1:0]  seq_q;

    logic                  reg_free;
    logic                  in_hs;
    logic                  last_beat;
    logic                  load_hdr;
    logic                  load_smp;
    logic [DATA_WIDTH-1:0] header_word;

    // Upstream framing is discarded; packets are delimited here instead.
    logic                  unused_s_tlast;
    assign unused_s_tlast = s_axis_tlast;

    // The output register can take a new beat when empty or draining this cycle,
    // which lets a load and an output handshake share a cycle without a bubble.
    assign reg_free      = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = (state_q == PAYLOAD) && reg_free;
    assign in_hs         = s_axis_tvalid && s_axis_tready;
    assign last_beat     = (beat_cnt_q == 16'(PACKET_LEN - 1));
    assign header_word   = DATA_WIDTH'(build_header(16'(PACKET_LEN), SEQ_FIELD_W'(seq_q)));
    assign o_busy        = (state_q != IDLE);

    // State register.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and load strobes for the output register.
    always_comb begin
        state_d  = state_q;
        load_hdr = 1'b0;
        load_smp = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_enable && s_axis_tvalid) begin
                    state_d = HEADER;
                end
            end
            HEADER: begin
                if (reg_free) begin
                    load_hdr = 1'b1;
                    state_d  = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (in_hs) begin
                    load_smp = 1'b1;
                    if (last_beat) begin
                        state_d = i_enable ? HEADER : IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Beat counter: cleared with each header, advanced on every accepted sample.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            beat_cnt_q <= '0;
        end else if (load_hdr) begin
            beat_cnt_q <= '0;
        end else if (load_smp) begin
            beat_cnt_q <= beat_cnt_q + 16'd1;
        end
    end

    // Sequence number advances once the last sample of a packet is taken.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            seq_q <= '0;
        end else if (load_smp && last_beat) begin
            seq_q <= seq_q + 1'b1;
        end
    end

    // Output register: data and tlast only change when the register is free,
    // so they hold steady for the whole of any downstream stall.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (load_hdr) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= header_word;
            m_axis_tlast  <= 1'b0;
        end else if (load_smp) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= s_axis_tdata;
            m_axis_tlast  <= last_beat;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    // Completed-packet counter, counted at the downstream tlast handshake.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            o_packet_count <= '0;
        end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
            o_packet_count <= o_packet_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_axis_adc_packetizer.sv
// Bench for axis_adc_packetizer. Instance A (PACKET_LEN=4, SEQ_WIDTH=2) runs
// randomized traffic against a packet-level reference model; instance B
// (PACKET_LEN=1) runs a short directed sequence.
module tb_axis_adc_packetizer;

    localparam int DW    = 32;
    localparam int LEN_A = 4;
    localparam int SEQ_A = 2;

    logic          axis_aclk = 1'b0;
    logic          axis_aresetn;

    logic          s_tvalid, s_tlast, s_tready;
    logic [DW-1:0] s_tdata;
    logic          m_tvalid, m_tlast, m_tready;
    logic [DW-1:0] m_tdata;
    logic          enable, busy;
    logic [31:0]   pkt_count;

    logic          b_s_tvalid, b_s_tlast, b_s_tready;
    logic [DW-1:0] b_s_tdata;
    logic          b_m_tvalid, b_m_tlast, b_m_tready;
    logic [DW-1:0] b_m_tdata;
    logic          b_enable, b_busy;
    logic [31:0]   b_pkt_count;

    int total = 0;
    int bad   = 0;

    logic [31:0] in_q[$];
    logic [32:0] exp_q[$];
    int          model_seq;
    int          model_pkts;
    int          accepted;
    int          en_limit;
    int          cyc;
    int          first_out;
    int          last_out;
    logic        hs_pending;
    logic        prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;

    int          b_idx;
    logic        b_hs_pending;
    logic [32:0] b_got[$];
    logic [32:0] b_exp[4];

    always #5 axis_aclk = ~axis_aclk;

    axis_adc_packetizer #(
        .DATA_WIDTH (DW),
        .PACKET_LEN (LEN_A),
        .SEQ_WIDTH  (SEQ_A)
    ) dut_a (
        .axis_aclk      (axis_aclk),
        .axis_aresetn   (axis_aresetn),
        .s_axis_tvalid  (s_tvalid),
        .s_axis_tdata   (s_tdata),
        .s_axis_tlast   (s_tlast),
        .s_axis_tready  (s_tready),
        .m_axis_tvalid  (m_tvalid),
        .m_axis_tdata   (m_tdata),
        .m_axis_tlast   (m_tlast),
        .m_axis_tready  (m_tready),
        .i_enable       (enable),
        .o_busy         (busy),
        .o_packet_count (pkt_count)
    );

    axis_adc_packetizer #(
        .DATA_WIDTH (DW),
        .PACKET_LEN (1),
        .SEQ_WIDTH  (16)
    ) dut_b (
        .axis_aclk      (axis_aclk),
        .axis_aresetn   (axis_aresetn),
        .s_axis_tvalid  (b_s_tvalid),
        .s_axis_tdata   (b_s_tdata),
        .s_axis_tlast   (b_s_tlast),
        .s_axis_tready  (b_s_tready),
        .m_axis_tvalid  (b_m_tvalid),
        .m_axis_tdata   (b_m_tdata),
        .m_axis_tlast   (b_m_tlast),
        .m_axis_tready  (b_m_tready),
        .i_enable       (b_enable),
        .o_busy         (b_busy),
        .o_packet_count (b_pkt_count)
    );

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, want);
        end
    endtask

    // Queue n packets worth of samples and the beats they should produce.
    task automatic plan_packets(input int n, input bit random_data, input logic [31:0] base);
        logic [31:0] v;
        for (int p = 0; p < n; p++) begin
            exp_q.push_back({1'b0, 32'((model_seq << 16) | LEN_A)});
            model_seq = (model_seq + 1) % (1 << SEQ_A);
            for (int i = 0; i < LEN_A; i++) begin
                v = random_data ? $urandom : base + 32'(p * LEN_A + i);
                in_q.push_back(v);
                exp_q.push_back({(i == LEN_A - 1), v});
            end
        end
    endtask

    // One clock cycle: drive at the falling edge, observe 1 ns later.
    task automatic apply_stimulus(input int rdy_pct, input int vld_pct);
        @(negedge axis_aclk);
        cyc++;
        if (hs_pending) begin
            s_tvalid   = 1'b0;
            hs_pending = 1'b0;
        end
        m_tready = ($urandom_range(99) < rdy_pct);
        enable   = (accepted < en_limit);
        s_tlast  = 1'($urandom_range(1));
        if (!s_tvalid && in_q.size() > 0 && $urandom_range(99) < vld_pct) begin
            s_tvalid = 1'b1;
            s_tdata  = in_q[0];
        end
        #1;
        if (prev_stall) begin
            check_output("hold_valid", 64'(m_tvalid), 64'd1);
            check_output("hold_data", 64'(m_tdata), 64'(prev_data));
            check_output("hold_last", 64'(m_tlast), 64'(prev_last));
        end
        prev_stall = m_tvalid && !m_tready;
        prev_data  = m_tdata;
        prev_last  = m_tlast;
        if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
                check_output("beat_expected", 64'(exp_q.size()), 64'd1);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                check_output("beat_data", 64'(m_tdata), 64'(e[31:0]));
                check_output("beat_last", 64'(m_tlast), 64'(e[32]));
                if (e[32]) model_pkts++;
            end
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
        end
        if (s_tvalid && s_tready) begin
            void'(in_q.pop_front());
            accepted++;
            hs_pending = 1'b1;
        end
    endtask

    // Run until all planned beats are out (stop_acc=0) or stop_acc samples taken.
    task automatic run_phase(input int rdy_pct, input int vld_pct, input int stop_acc,
                             input int en_lim, input int limit);
        int n;
        n         = 0;
        cyc       = 0;
        accepted  = 0;
        en_limit  = en_lim;
        first_out = -1;
        last_out  = -1;
        while (n < limit) begin
            if (stop_acc > 0 && accepted >= stop_acc) break;
            if (stop_acc <= 0 && exp_q.size() == 0 && in_q.size() == 0) break;
            apply_stimulus(rdy_pct, vld_pct);
            n++;
        end
        if (n >= limit) check_output("phase_timeout", 64'(n), 64'(limit - 1));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        axis_aresetn = 1'b0;
        s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; m_tready = 1'b0; enable = 1'b0;
        b_s_tvalid = 1'b0; b_s_tdata = '0; b_s_tlast = 1'b0; b_m_tready = 1'b0; b_enable = 1'b0;
        hs_pending = 1'b0; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
        model_seq = 0; model_pkts = 0; accepted = 0; en_limit = 0; cyc = 0;
        first_out = -1; last_out = -1;
        #12;
        check_output("rst_s_tready", 64'(s_tready), 64'd0);
        check_output("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        check_output("rst_m_tdata", 64'(m_tdata), 64'd0);
        check_output("rst_m_tlast", 64'(m_tlast), 64'd0);
        check_output("rst_busy", 64'(busy), 64'd0);
        check_output("rst_pkt_count", 64'(pkt_count), 64'd0);
        @(negedge axis_aclk);
        axis_aresetn = 1'b1;

        // Continuous input 1..8, downstream always ready.
        $display("[TB] phase: continuous two packets");
        plan_packets(2, 1'b0, 32'd1);
        run_phase(100, 100, 0, 2 * LEN_A - 3, 200);
        check_output("first_header_cycle", 64'(first_out), 64'd3);
        check_output("no_bubble_span", 64'(last_out - first_out), 64'(2 * (LEN_A + 1) - 1));
        repeat (3) apply_stimulus(100, 0);
        check_output("pkt_count_2", 64'(pkt_count), 64'(model_pkts));

        // Random backpressure and input gaps, sequence number wraps.
        $display("[TB] phase: random backpressure");
        plan_packets(3, 1'b1, 32'd0);
        run_phase(50, 70, 0, 3 * LEN_A - 2, 2000);
        repeat (3) apply_stimulus(100, 0);
        check_output("pkt_count_5", 64'(pkt_count), 64'(model_pkts));

        // Enable dropped after the second sample: packet still completes.
        $display("[TB] phase: enable drop mid-packet");
        plan_packets(1, 1'b1, 32'd0);
        run_phase(60, 100, 0, 2, 1000);
        repeat (4) apply_stimulus(100, 0);
        check_output("drop_s_tready", 64'(s_tready), 64'd0);
        check_output("drop_busy", 64'(busy), 64'd0);
        check_output("drop_m_tvalid", 64'(m_tvalid), 64'd0);
        check_output("pkt_count_6", 64'(pkt_count), 64'(model_pkts));

        // Reset asserted mid-payload, between clock edges.
        $display("[TB] phase: reset mid-payload");
        plan_packets(1, 1'b1, 32'd0);
        run_phase(100, 100, 2, 100, 200);
        @(posedge axis_aclk);
        #3;
        axis_aresetn = 1'b0;
        #1;
        check_output("arst_m_tvalid", 64'(m_tvalid), 64'd0);
        check_output("arst_m_tdata", 64'(m_tdata), 64'd0);
        check_output("arst_m_tlast", 64'(m_tlast), 64'd0);
        check_output("arst_s_tready", 64'(s_tready), 64'd0);
        check_output("arst_busy", 64'(busy), 64'd0);
        check_output("arst_pkt_count", 64'(pkt_count), 64'd0);
        in_q.delete();
        exp_q.delete();
        s_tvalid = 1'b0; hs_pending = 1'b0; prev_stall = 1'b0;
        model_seq = 0; model_pkts = 0;
        repeat (2) @(negedge axis_aclk);
        axis_aresetn = 1'b1;
        plan_packets(1, 1'b1, 32'd0);
        run_phase(100, 100, 0, LEN_A - 2, 200);
        repeat (3) apply_stimulus(100, 0);
        check_output("post_rst_pkt_count", 64'(pkt_count), 64'(model_pkts));

        // PACKET_LEN=1 instance: samples 9 and 10.
        $display("[TB] phase: single-sample packets");
        b_exp[0] = {1'b0, 32'h0000_0001};
        b_exp[1] = {1'b1, 32'd9};
        b_exp[2] = {1'b0, 32'h0001_0001};
        b_exp[3] = {1'b1, 32'd10};
        b_idx = 0;
        b_hs_pending = 1'b0;
        b_m_tready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge axis_aclk);
            if (b_hs_pending) begin
                b_idx++;
                b_hs_pending = 1'b0;
            end
            b_s_tvalid = (b_idx < 2);
            b_s_tdata  = (b_idx == 0) ? 32'd9 : 32'd10;
            b_enable   = (b_idx < 1);
            #1;
            if (b_s_tvalid && b_s_tready) b_hs_pending = 1'b1;
            if (b_m_tvalid && b_m_tready) b_got.push_back({b_m_tlast, b_m_tdata});
        end
        check_output("b_beat_count", 64'(b_got.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < b_got.size()) check_output("b_beat", 64'(b_got[i]), 64'(b_exp[i]));
        end
        check_output("b_pkt_count", 64'(b_pkt_count), 64'd2);
        check_output("b_busy_end", 64'(b_busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
